// File: rtl/multiplier_4bit.sv
// Two-stage registered 4x4 unsigned multiplier with valid flag.
// Product comes from an AND-gate partial-product array reduced by ripple full-adder rows.
module multiplier_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       out_valid
);

  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       v1;
  logic [3:0] pp [4];
  logic [7:0] prod;

  // Operands only load on valid cycles, so idle-cycle garbage on A/B never reaches the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v1  <= 1'b0;
    end else begin
      if (in_valid) begin
        a_q <= A;
        b_q <= B;
      end
      v1 <= in_valid;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a_q[j] & b_q[i];
      end
    end
  end

  // Each row adds the next partial product to the upper bits of the running sum;
  // the row's LSB retires as one product bit and its carry-out becomes the new MSB.
  always_comb begin
    logic [3:0] acc;
    logic [3:0] s;
    logic       c;
    prod    = '0;
    s       = '0;
    c       = 1'b0;
    prod[0] = pp[0][0];
    acc     = {1'b0, pp[0][3:1]};
    for (int i = 1; i < 4; i++) begin
      c = 1'b0;
      for (int j = 0; j < 4; j++) begin
        s[j] = acc[j] ^ pp[i][j] ^ c;
        c    = (acc[j] & pp[i][j]) | (c & (acc[j] ^ pp[i][j]));
      end
      prod[i] = s[0];
      acc     = {c, s[3:1]};
    end
    prod[7:4] = acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (v1) begin
        P <= prod;
      end
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_multiplier_4bit.sv
// Self-checking bench for multiplier_4bit: directed table, exhaustive sweep, random
// traffic against an arithmetic reference, plus bubble and reset corner sequences.
module tb_multiplier_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  // Reference: output after edge k reflects the pair accepted at edge k-1.
  logic       m_v_prev;
  logic [7:0] m_prod_prev;
  logic [7:0] m_p;
  logic       m_ov;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  multiplier_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .P         (P),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v_prev    = 1'b0;
    m_prod_prev = '0;
    m_p         = '0;
    m_ov        = 1'b0;
  endtask

  // Called at a negedge; drives one cycle of stimulus and checks the outputs it produces.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b, input bit xin);
    in_valid = v;
    if (xin) begin
      A = 'x;
      B = 'x;
    end else begin
      A = a;
      B = b;
    end
    @(posedge clk);
    m_ov = m_v_prev;
    if (m_v_prev) m_p = m_prod_prev;
    m_v_prev = v;
    m_prod_prev = 8'(int'(a) * int'(b));
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("P", int'(P), int'(m_p));
  endtask

  initial begin
    vecs = '{
      '{4'd0,  4'd0,  8'd0},
      '{4'd1,  4'd2,  8'd2},
      '{4'd3,  4'd3,  8'd9},
      '{4'd10, 4'd4,  8'h28},
      '{4'd15, 4'd15, 8'hE1},
      '{4'd15, 4'd1,  8'd15},
      '{4'd1,  4'd15, 8'd15},
      '{4'd8,  4'd8,  8'd64},
      '{4'd15, 4'd0,  8'd0}
    };

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_P", int'(P), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;

    // Directed table streamed back to back
    for (int k = 0; k <= 9; k++) begin
      if (k < 9) cycle(1'b1, vecs[k].a, vecs[k].b, 1'b0);
      else       cycle(1'b0, 4'd0, 4'd0, 1'b0);
      if (k > 0) begin
        chk("table_valid", int'(out_valid), 1);
        chk("table_P", int'(P), int'(vecs[k-1].exp));
      end
    end
    cycle(1'b0, 4'd0, 4'd0, 1'b0);

    // Exhaustive sweep, back to back
    for (int k = 0; k < 257; k++) begin
      if (k < 256) cycle(1'b1, 4'(k >> 4), 4'(k & 15), 1'b0);
      else         cycle(1'b0, 4'd0, 4'd0, 1'b0);
    end
    cycle(1'b0, 4'd0, 4'd0, 1'b0);

    // Random traffic with bubbles
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end
    cycle(1'b0, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 4'd0, 1'b0);

    // Bubble and hold with unknown operands while idle
    cycle(1'b1, 4'd7, 4'd9, 1'b0);
    cycle(1'b0, 4'd0, 4'd0, 1'b1);
    chk("bubble_pulse", int'(out_valid), 1);
    chk("bubble_P", int'(P), 63);
    cycle(1'b0, 4'd0, 4'd0, 1'b1);
    chk("bubble_hold_valid", int'(out_valid), 0);
    chk("bubble_hold_P", int'(P), 63);
    cycle(1'b0, 4'd0, 4'd0, 1'b1);
    chk("bubble_hold_P2", int'(P), 63);

    // Reset mid-flight: asynchronous clear, overrides in_valid, in-flight pair dropped
    cycle(1'b1, 4'd12, 4'd13, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_P", int'(P), 0);
    chk("async_reset_valid", int'(out_valid), 0);
    in_valid = 1'b1;
    A = 4'd5;
    B = 4'd5;
    @(posedge clk);
    @(negedge clk);
    chk("reset_override_valid", int'(out_valid), 0);
    chk("reset_override_P", int'(P), 0);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 4'd2, 4'd8, 1'b0);
    chk("post_reset_no_stale", int'(out_valid), 0);
    cycle(1'b0, 4'd0, 4'd0, 1'b0);
    chk("post_reset_valid", int'(out_valid), 1);
    chk("post_reset_P", int'(P), 16);
    cycle(1'b0, 4'd0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
